// File: rtl/helper_axis_pkg.sv
// helper_axis_pkg: shared checker states and 16-bit LFSR constants for the stream helpers
package helper_axis_pkg;
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;
  localparam int LFSR_W = 16;
  localparam int TAP_A = 16;
  localparam int TAP_B = 14;
  localparam int TAP_C = 13;
  localparam int TAP_D = 11;
  localparam logic [LFSR_W-1:0] TAP_MASK = LFSR_W'((1 << (LFSR_W - TAP_A)) | (1 << (LFSR_W - TAP_B)) |
                                                   (1 << (LFSR_W - TAP_C)) | (1 << (LFSR_W - TAP_D)));
  function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] s);
    return {^(s & TAP_MASK), s[LFSR_W-1:1]};
  endfunction
endpackage

// File: rtl/helper_lfsr16.sv
// helper_lfsr16: 16-bit Fibonacci LFSR that shifts right only when advance is high
module helper_lfsr16
  import helper_axis_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              advance,
  input  logic [LFSR_W-1:0] seed,
  output logic [LFSR_W-1:0] state
);
  logic [LFSR_W-1:0] state_q;
  // load the seed on active-low reset, otherwise shift once per enabled cycle
  always_ff @(posedge clk) begin
    if (!rst) state_q <= seed;
    else if (advance) state_q <= lfsr_step(state_q);
  end
  assign state = state_q;
endmodule

// File: rtl/helper_axis_checker.sv
// helper_axis_checker: stream sink with back-pressure, sequence checking and handshake monitoring
module helper_axis_checker
  import helper_axis_pkg::*;
#(
  parameter int                DATA_WIDTH     = 10,
  parameter int                CHECK_DATA     = 1,
  parameter int                READY_MODE     = 1,
  parameter logic [LFSR_W-1:0] LFSR_SEED      = 16'hACE1,
  parameter int                COUNT_WIDTH    = 16,
  parameter int                EXPECTED_COUNT = 100
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   enable,
  input  logic                   input_valid,
  input  logic [DATA_WIDTH-1:0]  input_data,
  output logic                   input_ready,
  output logic [COUNT_WIDTH-1:0] transfer_count,
  output logic                   mismatch,
  output logic [COUNT_WIDTH-1:0] first_mismatch_index,
  output logic                   protocol_error,
  output logic                   done
);
  state_e                 state_q, state_d;
  logic                   ready_q, ready_d;
  logic [COUNT_WIDTH-1:0] count_q, count_d, fmi_q, fmi_d;
  logic                   mm_q, mm_d, pe_q, pe_d, stall_q, stall_d;
  logic [DATA_WIDTH-1:0]  exp_q, exp_d, prev_q;
  logic [LFSR_W-1:0]      lfsr, lfsr_nx;
  logic                   advance, xfer, last, bad;
  logic                   unused_lfsr;

  assign advance     = state_q == S_RUN;
  assign lfsr_nx     = lfsr_step(lfsr);
  assign unused_lfsr = ^lfsr_nx[LFSR_W-1:1];
  assign xfer        = input_valid & ready_q;
  assign last        = xfer && count_q == COUNT_WIDTH'(EXPECTED_COUNT - 1);
  assign bad         = CHECK_DATA != 0 && xfer && input_data != exp_q;

  helper_lfsr16 u_lfsr (
    .clk    (clk),
    .rst    (rst),
    .advance(advance),
    .seed   (LFSR_SEED),
    .state  (lfsr)
  );

  // run control; ready is only raised for cycles that begin and stay in S_RUN
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  state_d = enable ? S_RUN : S_IDLE;
      S_RUN:   state_d = last ? S_DONE : (enable ? S_RUN : S_IDLE);
      default: state_d = S_DONE;
    endcase
    ready_d = (state_q == S_RUN && state_d == S_RUN) ? (READY_MODE != 0 ? lfsr_nx[0] : 1'b1) : 1'b0;
  end

  // counters, sticky flags and stall tracking for the handshake monitor
  always_comb begin
    count_d = xfer ? count_q + 1'b1 : count_q;
    exp_d   = xfer ? exp_q + 1'b1 : exp_q;
    mm_d    = mm_q | bad;
    fmi_d   = (bad && !mm_q) ? count_q : fmi_q;
    pe_d    = pe_q | (stall_q && (!input_valid || input_data != prev_q));
    stall_d = input_valid & ~ready_q;
  end

  // register everything; active-low reset returns all outputs to idle values
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      ready_q <= 1'b0;
      count_q <= '0;
      exp_q   <= '0;
      mm_q    <= 1'b0;
      fmi_q   <= '0;
      pe_q    <= 1'b0;
      stall_q <= 1'b0;
      prev_q  <= '0;
    end else begin
      state_q <= state_d;
      ready_q <= ready_d;
      count_q <= count_d;
      exp_q   <= exp_d;
      mm_q    <= mm_d;
      fmi_q   <= fmi_d;
      pe_q    <= pe_d;
      stall_q <= stall_d;
      prev_q  <= input_data;
    end
  end

  assign input_ready          = ready_q;
  assign transfer_count       = count_q;
  assign mismatch             = mm_q;
  assign first_mismatch_index = fmi_q;
  assign protocol_error       = pe_q;
  assign done                 = state_q == S_DONE;
endmodule

// File: doc/helper_axis_checker.md
# helper_axis_checker

Testbench sink for the AXI-Stream style valid/ready bus: accepts words from a stream source, drives `input_ready` with a constant or pseudo-random back-pressure pattern, and checks the received data against an incrementing reference sequence. It counts transfers, flags data mismatches and handshake-protocol violations, and asserts `done` after a programmed number of transfers. It pairs with the stream generator in unit benches and sits at the output of any block under test.

## Interface
- `DATA_WIDTH`, 10, stream data width
- `CHECK_DATA`, 1, 1 = compare data against incrementing sequence; 0 = drain only
- `READY_MODE`, 1, 0 = ready held high while running; 1 = ready driven by LFSR bit 0
- `LFSR_SEED`, 16'hACE1, initial LFSR value, must be nonzero
- `COUNT_WIDTH`, 16, width of counters and index outputs
- `EXPECTED_COUNT`, 100, transfers to accept before `done`, range 1..2^COUNT_WIDTH-1
- `clk`  in  1  clock, all logic on rising edge
- `rst`  in  1  synchronous, active-low reset
- `enable`  in  1  run request
- `input_valid`  in  1  source has data
- `input_data`  in  DATA_WIDTH  stream data
- `input_ready`  out  1  registered ready
- `transfer_count`  out  COUNT_WIDTH  accepted transfers
- `mismatch`  out  1  sticky data-mismatch flag
- `first_mismatch_index`  out  COUNT_WIDTH  transfer index of first mismatch
- `protocol_error`  out  1  sticky handshake-violation flag
- `done`  out  1  EXPECTED_COUNT transfers accepted

## Operation
- Transfer = `input_valid & input_ready` on a rising edge.
- States: S_IDLE, S_RUN, S_DONE. Reset -> S_IDLE.
- S_IDLE -> S_RUN when `enable`=1. S_RUN -> S_IDLE when `enable`=0 (counters/flags retained). S_RUN -> S_DONE on the transfer making count = EXPECTED_COUNT. S_DONE absorbing until reset.
- Ready next value: S_RUN-bound and READY_MODE=0 -> 1; READY_MODE=1 -> next LFSR bit 0; otherwise 0. Ready is 0 in the cycle after entering S_IDLE or S_DONE.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11, shifts once per cycle in S_RUN only, held elsewhere.
- Expected value: DATA_WIDTH-bit counter from 0, +1 per transfer, wraps modulo 2^DATA_WIDTH, advances regardless of mismatch.
- Data check (CHECK_DATA=1): on transfer with `input_data` != expected, set `mismatch`; if first, capture `transfer_count` (pre-increment) into `first_mismatch_index`.
- Protocol check, all states after reset: if previous cycle had valid=1, ready=0, then this cycle requires valid=1 and data equal to registered previous data; otherwise set `protocol_error`.
- `transfer_count` saturates at EXPECTED_COUNT (no further transfers possible since ready=0).

## Timing
- Reset values: `input_ready`=0, `transfer_count`=0, `mismatch`=0, `first_mismatch_index`=0, `protocol_error`=0, `done`=0, LFSR=LFSR_SEED, expected=0, stall register cleared.
- `enable` rise at edge t -> state S_RUN after t, `input_ready` first high after edge t+1 (READY_MODE=0).
- Counters, flags, `done` update on the edge of the qualifying transfer (visible next cycle).
- Last transfer at edge t: `done`=1 and `input_ready`=0 after t.
- `enable` drop and transfer on the same edge: transfer counted, then S_IDLE.
- Reset low mid-stream overrides everything on that edge; all outputs return to reset values.

## Structure
- Package `helper_axis_pkg`: state enum (S_IDLE, S_RUN, S_DONE), LFSR width 16 and tap constants.
- Sub-module `helper_lfsr16` (clk, rst, advance, seed, state out); reused by future randomized helpers.

## Test plan
- READY_MODE=0, source incrementing from 0, EXPECTED_COUNT=100 -> 100 transfers in 100 consecutive cycles, `done`=1, `mismatch`=0, `protocol_error`=0, ready low after.
- READY_MODE=1, seed 16'hACE1, same source -> ready toggles per LFSR, `transfer_count`=100, no flags; cycle count matches LFSR ready-ones count.
- Source skips value 37 (sends 38 at index 37) -> `mismatch`=1, `first_mismatch_index`=37, later mismatches do not change index.
- Source drops valid while ready=0 at a stall -> `protocol_error`=1 next cycle; changing data during stall also sets it.
- DATA_WIDTH=4, EXPECTED_COUNT=40 -> expected wraps 15->0, no mismatch, `done`=1.
- `rst`=0 at transfer 50 then re-enable -> all outputs zero, count restarts from 0, full 100 accepted with source restarted.
